// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 8-bit CPU: fetches two-byte instructions, sequences ALU/RF/RAM,
// holds the architectural PC and C/Z flags, and guards RAM accesses with a ready timeout.
module cpu_sequencer #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] ram_addr,
  output logic       ram_n_cs,
  output logic       ram_n_oe,
  output logic       ram_n_we,
  input  logic       ram_ready,
  output logic [2:0] rf_raddr1,
  output logic [2:0] rf_raddr2,
  output logic [2:0] rf_waddr,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic [7:0] imm,
  output logic       alu_op,
  output logic [2:0] alu_func,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       carry_f,
  output logic       zero_f,
  output logic [7:0] pc,
  output logic       halted,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  ir1_q, ir1_d;
  logic [7:0]  ir2_q, ir2_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic [15:0] tmo_q, tmo_d;

  logic is_alu, is_ldi, is_ldm, is_st, is_jmp, is_halt, jmp_taken;

  always_comb begin
    is_alu  = ir1_q[7];
    is_ldi  = (ir1_q[7:4] == 4'h1);
    is_ldm  = (ir1_q[7:4] == 4'h2);
    is_st   = (ir1_q[7:4] == 4'h3);
    is_jmp  = (ir1_q[7:4] == 4'h4);
    is_halt = (ir1_q == 8'h0F);
    unique case (ir1_q[2:0])
      3'b000:  jmp_taken = 1'b1;
      3'b001:  jmp_taken = carry_q;
      3'b101:  jmp_taken = !carry_q;
      3'b010:  jmp_taken = zero_q;
      3'b110:  jmp_taken = !zero_q;
      default: jmp_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir1_q   <= '0;
      ir2_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir1_q   <= ir1_d;
      ir2_q   <= ir2_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir1_d   = ir1_q;
    ir2_d   = ir2_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH1;
      S_FETCH1: begin
        ir1_d   = rom_data;
        state_d = S_FETCH2;
      end
      S_FETCH2: begin
        ir2_d   = rom_data;
        pc_d    = pc_q + 8'd2;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        tmo_d = '0;
        if (is_alu || is_jmp)    state_d = S_EXEC;
        else if (is_ldi)         state_d = S_WB;
        else if (is_ldm || is_st) state_d = S_MEM;
        else if (is_halt)        state_d = S_HALT;
        else                     state_d = S_FETCH1;
      end
      S_EXEC: begin
        if (is_alu) begin
          carry_d = alu_carry;
          zero_d  = alu_zero;
          state_d = S_WB;
        end else begin
          if (jmp_taken) pc_d = ir2_q;
          state_d = S_FETCH1;
        end
      end
      S_MEM: begin
        // A zero limit never matches the incremented count, so the wait is unbounded.
        if (ram_ready) begin
          tmo_d   = '0;
          state_d = is_ldm ? S_WB : S_FETCH1;
        end else if ((TMO_LIMIT != '0) && (tmo_q + 16'd1 == TMO_LIMIT)) begin
          tmo_d   = tmo_q + 16'd1;
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WB:    state_d = S_FETCH1;
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rom_addr = pc_q;
    ram_n_cs = 1'b1;
    ram_n_oe = 1'b1;
    ram_n_we = 1'b1;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    alu_op   = 1'b0;
    unique case (state_q)
      S_FETCH2: rom_addr = pc_q + 8'd1;
      S_EXEC:   alu_op = is_alu;
      S_MEM: begin
        ram_n_cs = 1'b0;
        ram_n_oe = !is_ldm;
        ram_n_we = !is_st;
      end
      S_WB: begin
        rf_we = 1'b1;
        if (is_alu) begin
          wb_sel = 2'b10;
          alu_op = 1'b1;
        end else if (is_ldm) begin
          wb_sel   = 2'b01;
          ram_n_cs = 1'b0;
          ram_n_oe = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign ram_addr  = ir2_q;
  assign imm       = ir2_q;
  assign rf_raddr1 = ir1_q[2:0];
  assign rf_raddr2 = is_st ? ir1_q[2:0] : ir2_q[2:0];
  assign rf_waddr  = ir1_q[2:0];
  assign alu_func  = ir1_q[6:4];
  assign carry_f   = carry_q;
  assign zero_f    = zero_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT) || (state_q == S_ERROR);
  assign err       = (state_q == S_ERROR);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: one-instruction programs from a vector table, writebacks
// checked against a scoreboard queue, plus hand sequences for timeout, PC wrap and reset.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] rom_addr, rom_data, ram_addr, imm, pc;
  logic       ram_n_cs, ram_n_oe, ram_n_we, ram_ready;
  logic [2:0] rf_raddr1, rf_raddr2, rf_waddr, alu_func;
  logic       rf_we, alu_op, alu_carry, alu_zero, carry_f, zero_f, halted, err;
  logic [1:0] wb_sel;

  always #5 clk = ~clk;

  cpu_sequencer #(.RESET_PC(8'h00), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_n_cs(ram_n_cs), .ram_n_oe(ram_n_oe), .ram_n_we(ram_n_we),
    .ram_ready(ram_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .wb_sel(wb_sel), .imm(imm), .alu_op(alu_op), .alu_func(alu_func),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .carry_f(carry_f), .zero_f(zero_f),
    .pc(pc), .halted(halted), .err(err)
  );

  logic [7:0] rom [256];
  assign rom_data = rom[rom_addr];

  // RAM model: ready after wait_cfg cycles of chip select, or never
  int         wait_cfg = 0;
  bit         never_ready = 1'b0;
  logic [7:0] wcnt = 8'd0;
  always @(posedge clk) wcnt <= ram_n_cs ? 8'd0 : wcnt + 8'd1;
  assign ram_ready = !never_ready && (int'(wcnt) >= wait_cfg);

  typedef struct {
    logic [2:0] waddr;
    logic [1:0] sel;
    logic [7:0] imm;
    logic       alu_op;
    logic [2:0] func;
    logic       n_oe;
  } wb_t;
  wb_t sbq[$];

  typedef struct {
    logic [7:0] ir1, ir2;
    logic       c, z;
    int         w, cycles;
    logic [7:0] pc;
    bit         wb;
    logic [2:0] waddr;
    logic [1:0] sel;
    int         cs;
  } vec_t;
  vec_t vecs[20];

  int         errors = 0, checks = 0;
  int         cs_cnt = 0;
  logic [7:0] cur_ram_addr = 8'h00;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic [2:0] waddr, input logic [1:0] sel,
                         input logic [7:0] im, input logic [2:0] func);
    wb_t e;
    e.waddr = waddr; e.sel = sel; e.imm = im; e.func = func;
    e.alu_op = (sel == 2'b10);
    e.n_oe   = (sel != 2'b01);
    sbq.push_back(e);
  endtask

  // One clock: sample 1ns after the edge, check strobe rules and pop writebacks
  task automatic step();
    wb_t e;
    @(posedge clk);
    #1;
    check_eq("oe_we_exclusive", {31'd0, !(!ram_n_oe && !ram_n_we)}, 32'd1);
    if (!ram_n_cs) begin
      cs_cnt++;
      check_eq("ram_addr", {24'd0, ram_addr}, {24'd0, cur_ram_addr});
    end
    if (rf_we) begin
      if (sbq.size() == 0) check_eq("unexpected_rf_we", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        check_eq("rf_waddr", {29'd0, rf_waddr}, {29'd0, e.waddr});
        check_eq("wb_sel", {30'd0, wb_sel}, {30'd0, e.sel});
        check_eq("imm", {24'd0, imm}, {24'd0, e.imm});
        check_eq("wb_alu_op", {31'd0, alu_op}, {31'd0, e.alu_op});
        check_eq("wb_ram_n_oe", {31'd0, ram_n_oe}, {31'd0, e.n_oe});
        if (e.alu_op) check_eq("wb_alu_func", {29'd0, alu_func}, {29'd0, e.func});
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    never_ready = 1'b0;
    wait_cfg = 0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic run_to_halt(output int n);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!halted && n < 200) begin
      step();
      n++;
    end
  endtask

  function automatic vec_t mk(input logic [7:0] ir1, input logic [7:0] ir2, input logic c,
                              input logic z, input int w, input int cycles, input logic [7:0] p,
                              input bit wb, input logic [2:0] wa, input logic [1:0] sel, input int cs);
    vec_t v;
    v.ir1 = ir1; v.ir2 = ir2; v.c = c; v.z = z; v.w = w; v.cycles = cycles; v.pc = p;
    v.wb = wb; v.waddr = wa; v.sel = sel; v.cs = cs;
    return v;
  endfunction

  initial begin
    int n, cs0;
    reset = 1'b1; start = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0;
    clear_rom();

    // cycles = 5 (ALU prefix) + instruction cycles + 3 (HALT)
    vecs[0]  = mk(8'h00, 8'h00, 0, 0, 0, 11, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[1]  = mk(8'h13, 8'h05, 0, 1, 0, 12, 8'h06, 1, 3'd3, 2'b00, 0);
    vecs[2]  = mk(8'h22, 8'h30, 1, 0, 0, 13, 8'h06, 1, 3'd2, 2'b01, 2);
    vecs[3]  = mk(8'h24, 8'h31, 0, 0, 2, 15, 8'h06, 1, 3'd4, 2'b01, 4);
    vecs[4]  = mk(8'h35, 8'h40, 1, 1, 3, 15, 8'h06, 0, 3'd0, 2'b00, 4);
    vecs[5]  = mk(8'h91, 8'h06, 1, 0, 0, 13, 8'h06, 1, 3'd1, 2'b10, 0);
    vecs[6]  = mk(8'h40, 8'h20, 0, 0, 0, 12, 8'h22, 0, 3'd0, 2'b00, 0);
    vecs[7]  = mk(8'h41, 8'h20, 1, 0, 0, 12, 8'h22, 0, 3'd0, 2'b00, 0);
    vecs[8]  = mk(8'h41, 8'h20, 0, 1, 0, 12, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[9]  = mk(8'h45, 8'h20, 1, 0, 0, 12, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[10] = mk(8'h45, 8'h20, 0, 0, 0, 12, 8'h22, 0, 3'd0, 2'b00, 0);
    vecs[11] = mk(8'h42, 8'h20, 0, 1, 0, 12, 8'h22, 0, 3'd0, 2'b00, 0);
    vecs[12] = mk(8'h42, 8'h20, 1, 0, 0, 12, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[13] = mk(8'h46, 8'h20, 0, 1, 0, 12, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[14] = mk(8'h46, 8'h20, 1, 0, 0, 12, 8'h22, 0, 3'd0, 2'b00, 0);
    vecs[15] = mk(8'h43, 8'h20, 1, 1, 0, 12, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[16] = mk(8'h44, 8'h20, 1, 1, 0, 12, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[17] = mk(8'h47, 8'h20, 1, 1, 0, 12, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[18] = mk(8'h55, 8'h00, 0, 0, 0, 11, 8'h06, 0, 3'd0, 2'b00, 0);
    vecs[19] = mk(8'hF7, 8'h03, 0, 1, 0, 13, 8'h06, 1, 3'd7, 2'b10, 0);

    // Reset state
    step();
    check_eq("rst_pc", {24'd0, pc}, 32'h00);
    check_eq("rst_strobes", {29'd0, ram_n_cs, ram_n_oe, ram_n_we}, 32'h7);
    check_eq("rst_ctrl", {27'd0, rf_we, alu_op, wb_sel, halted}, 32'h0);
    check_eq("rst_flags", {29'd0, carry_f, zero_f, err}, 32'h0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      do_reset();
      clear_rom();
      rom[0] = 8'h80; rom[1] = 8'h00;
      rom[2] = vecs[i].ir1; rom[3] = vecs[i].ir2;
      rom[4] = 8'h0F; rom[8'h20] = 8'h0F;
      alu_carry = vecs[i].c; alu_zero = vecs[i].z;
      wait_cfg = vecs[i].w;
      cur_ram_addr = vecs[i].ir2;
      push_wb(3'd0, 2'b10, 8'h00, 3'd0);
      if (vecs[i].wb) push_wb(vecs[i].waddr, vecs[i].sel, vecs[i].ir2, vecs[i].ir1[6:4]);
      cs0 = cs_cnt;
      run_to_halt(n);
      check_eq($sformatf("v%0d_cycles", i), n, vecs[i].cycles);
      check_eq($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, vecs[i].pc});
      check_eq($sformatf("v%0d_flags", i), {30'd0, carry_f, zero_f}, {30'd0, vecs[i].c, vecs[i].z});
      check_eq($sformatf("v%0d_err", i), {31'd0, err}, 32'd0);
      check_eq($sformatf("v%0d_cs_cycles", i), cs_cnt - cs0, vecs[i].cs);
      check_eq($sformatf("v%0d_sb_empty", i), sbq.size(), 0);
    end

    // LDI r0,5 ; HALT: writeback lands in the fourth cycle after entering FETCH1
    do_reset();
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h05; rom[2] = 8'h0F;
    push_wb(3'd0, 2'b00, 8'h05, 3'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("ldi_no_early_we", {31'd0, rf_we}, 32'd0);
    step();
    check_eq("ldi_we_cycle", {31'd0, rf_we}, 32'd1);
    n = 0;
    while (!halted && n < 50) begin step(); n++; end
    check_eq("ldi_halted", {31'd0, halted}, 32'd1);
    check_eq("ldi_pc", {24'd0, pc}, 32'h04);

    // RAM never ready: ERROR after 15 waiting cycles
    do_reset();
    clear_rom();
    rom[0] = 8'h22; rom[1] = 8'h30; rom[2] = 8'h0F;
    never_ready = 1'b1;
    cur_ram_addr = 8'h30;
    cs0 = cs_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!err && n < 100) begin step(); n++; end
    check_eq("tmo_cycles", n, 18);
    check_eq("tmo_wait_cycles", cs_cnt - cs0, 15);
    check_eq("tmo_halted", {31'd0, halted}, 32'd1);
    check_eq("tmo_strobes", {29'd0, ram_n_cs, ram_n_oe, ram_n_we}, 32'h7);
    step();
    check_eq("tmo_err_held", {31'd0, err}, 32'd1);

    // PC wrap: JMP FF, then fetch at FF/00 and pc becomes 01
    do_reset();
    clear_rom();
    rom[0] = 8'h40; rom[1] = 8'hFF; rom[8'hFF] = 8'h0F;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 4) check_eq("wrap_f1_addr", {24'd0, rom_addr}, 32'hFF);
      if (k == 5) check_eq("wrap_f2_addr", {24'd0, rom_addr}, 32'h00);
    end
    check_eq("wrap_pc", {24'd0, pc}, 32'h01);
    step();
    check_eq("wrap_halted", {31'd0, halted}, 32'd1);

    // Flags hold, start ignored mid-run, async reset in the middle of a store
    do_reset();
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h00; rom[2] = 8'h33; rom[3] = 8'h50;
    alu_carry = 1'b1; alu_zero = 1'b1;
    never_ready = 1'b1;
    cur_ram_addr = 8'h50;
    push_wb(3'd0, 2'b10, 8'h00, 3'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (ram_n_cs && n < 50) begin step(); n++; end
    alu_carry = 1'b0; alu_zero = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("mid_start_ignored", {30'd0, ram_n_cs, ram_n_we}, 32'd0);
    check_eq("st_rs_addr", {26'd0, rf_raddr1, rf_raddr2}, {26'd0, 3'd3, 3'd3});
    check_eq("flags_held", {30'd0, carry_f, zero_f}, 32'h3);
    #2 reset = 1'b1;
    #1;
    check_eq("async_strobes", {29'd0, ram_n_cs, ram_n_oe, ram_n_we}, 32'h7);
    check_eq("async_pc", {24'd0, pc}, 32'h00);
    check_eq("async_flags", {29'd0, carry_f, zero_f, halted}, 32'h0);
    step();
    reset = 1'b0;
    step();
    check_eq("post_reset_idle", {29'd0, ram_n_cs, halted, err}, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
